// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM->WB pipeline boundary: default widths,
// the default-width payload record and its all-zero value.
package pipe_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned DEF_RADDR_W = 5;

  // Payload carried from MEM to WB at the default widths.
  typedef struct packed {
    logic [XLEN-1:0]        instr;
    logic [XLEN-1:0]        pc;
    logic                   we;
    logic [DEF_RADDR_W-1:0] waddr;
    logic [XLEN-1:0]        wdata;
  } wb_payload_t;

  localparam wb_payload_t WB_PAYLOAD_ZERO = '0;

  // Packed width of a payload for a given set of field widths.
  function automatic int unsigned payload_w(int unsigned instr_w, int unsigned pc_w,
                                            int unsigned raddr_w, int unsigned data_w);
    return instr_w + pc_w + 1 + raddr_w + data_w;
  endfunction

endpackage

// File: rtl/skid_buf_2.sv
// Generic 2-entry valid/ready buffer over an opaque payload vector.
// A head register drives the output; a skid register catches one extra entry
// so the upstream ready is a flop and never depends combinationally on
// out_ready. clear kills both entries and zeroes their payloads.
module skid_buf_2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         hv_q, hv_d;
  logic         sv_q, sv_d;
  logic         rdy_q;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire;

  assign in_fire = in_valid & rdy_q;

  // Next-state: kill, then advance head, then park input in the skid slot.
  always_comb begin
    hv_d   = hv_q;
    sv_d   = sv_q;
    head_d = head_q;
    skid_d = skid_q;
    if (reset || clear) begin
      hv_d   = 1'b0;
      sv_d   = 1'b0;
      head_d = '0;
      skid_d = '0;
    end else if (!hv_q || out_ready) begin
      if (sv_q) begin
        head_d = skid_q;
        hv_d   = 1'b1;
        sv_d   = 1'b0;
        // Unreachable while rdy_q == !sv_q; kept so a refill is never lost.
        if (in_fire) begin
          skid_d = in_data;
          sv_d   = 1'b1;
        end
      end else if (in_fire) begin
        head_d = in_data;
        hv_d   = 1'b1;
      end else begin
        hv_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d = in_data;
      sv_d   = 1'b1;
    end
  end

  // State registers; ready is its own flop so it has no path from out_ready.
  always_ff @(posedge clk) begin
    hv_q   <= hv_d;
    sv_q   <= sv_d;
    head_q <= head_d;
    skid_q <= skid_d;
    rdy_q  <= !sv_d;
  end

  assign in_ready  = rdy_q;
  assign out_valid = hv_q;
  assign out_data  = head_q;

endmodule

// File: rtl/wb_pipe_skid.sv
// MEM->WB boundary register with valid/ready on both sides and a 2-entry
// skid buffer. Adds synchronous flush, r0 write masking and, when the macro
// WBPIPE_STALL_CNT_EN is defined, stall and skid-load counters.
module wb_pipe_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = XLEN,
  parameter int unsigned PC_W    = XLEN,
  parameter int unsigned INSTR_W = XLEN,
  parameter int unsigned RADDR_W = DEF_RADDR_W,
  parameter bit          MASK_R0 = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               m_valid,
  output logic               m_ready,
  input  logic [INSTR_W-1:0] m_instr,
  input  logic [PC_W-1:0]    m_pc,
  input  logic               m_we,
  input  logic [RADDR_W-1:0] m_waddr,
  input  logic [DATA_W-1:0]  m_wdata,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [INSTR_W-1:0] w_instr,
  output logic [PC_W-1:0]    w_pc,
  output logic               w_we,
  output logic [RADDR_W-1:0] w_waddr,
  output logic [DATA_W-1:0]  w_wdata
`ifdef WBPIPE_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [15:0]        skid_hits
`endif
);

  localparam int unsigned PW = payload_w(INSTR_W, PC_W, RADDR_W, DATA_W);

  logic [PW-1:0] in_data;
  logic [PW-1:0] head_data;
  logic          head_we;

  assign in_data = {m_instr, m_pc, m_we, m_waddr, m_wdata};

  skid_buf_2 #(
    .W(PW)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .in_valid (m_valid),
    .in_ready (m_ready),
    .in_data  (in_data),
    .out_valid(w_valid),
    .out_ready(w_ready),
    .out_data (head_data)
  );

  assign {w_instr, w_pc, head_we, w_waddr, w_wdata} = head_data;

  // Write enable is the only combinational output: gated by valid and r0.
  always_comb begin
    w_we = head_we & w_valid;
    if (MASK_R0 && (w_waddr == '0)) begin
      w_we = 1'b0;
    end
  end

`ifdef WBPIPE_STALL_CNT_EN
  logic        skid_load;
  logic [31:0] stall_q;
  logic [15:0] hits_q;

  // With the skid empty, an accepted entry lands in it only when head stalls.
  assign skid_load = m_valid & m_ready & w_valid & !w_ready & !flush;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      hits_q  <= '0;
    end else begin
      if (w_valid && !w_ready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (skid_load) begin
        hits_q <= hits_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign skid_hits = hits_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: doc/wb_pipe_skid.md
Name: wb_pipe_skid

Overview:
- Parametrised MEM->WB boundary register; next generation of the fixed-width MEM/WB latch.
- Adds a valid/ready handshake on both sides and a 2-entry skid buffer, so WB back-pressure never combinationally reaches MEM.
- Keeps synchronous flush (exception/interrupt request), generalised field widths and optional r0 write masking.
- Sits between the MEM stage and register-file write port / forwarding network.

Parameters:
- DATA_W, 32, register write-data width
- PC_W, 32, pc field width
- INSTR_W, 32, instruction field width
- RADDR_W, 5, register address width
- MASK_R0, 1, 1 = write enable forced low when address is 0

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all held entries (exception/interrupt request)
- m_valid  in  1  MEM offers an entry
- m_ready  out  1  stage can accept; registered, equals !skid_valid
- m_instr  in  INSTR_W  instruction
- m_pc  in  PC_W  pc
- m_we  in  1  register write request
- m_waddr  in  RADDR_W  destination register
- m_wdata  in  DATA_W  write data
- w_valid  out  1  head entry valid
- w_ready  in  1  WB consumes head this cycle
- w_instr  out  INSTR_W  head instruction
- w_pc  out  PC_W  head pc
- w_we  out  1  m_we of head AND w_valid AND (MASK_R0 ? w_waddr!=0 : 1)
- w_waddr  out  RADDR_W  head destination
- w_wdata  out  DATA_W  head data

Behaviour:
- Storage: head register (drives w_*) with valid bit hv; skid register with valid bit sv. w_valid = hv.
- Handshakes:
  - in_fire = m_valid & m_ready.
  - out_fire = hv & w_ready.
  - m_ready = !sv, a direct flop output with no combinational path from w_ready.
- Update priority per cycle, highest first:
  1. reset | flush: hv <= 0, sv <= 0, all head and skid payload fields <= 0. Any in_fire in the same cycle is dropped.
  2. head empty or out_fire:
     - if sv: head <= skid, sv <= 0, and if in_fire then skid <= input, sv <= 1.
     - else if in_fire: head <= input, hv <= 1.
     - else hv <= 0; head payload holds its value.
  3. head held (hv & !w_ready) and in_fire: skid <= input, sv <= 1.
- Note on case 2: in_fire cannot occur while sv=1, because m_ready=0; the skid-refill branch is therefore unreachable but is coded defensively.
- Latency: 1 cycle from in_fire to w_valid when empty. Throughput: 1 entry/cycle with w_ready held high.
- Ordering: strict FIFO, never more than 2 entries. Overflow is impossible by construction.
- Simultaneous in_fire and out_fire with sv=0: head replaced by input, hv stays 1.
- w_ready while hv=0: ignored.
- Combinational output: w_we is the only combinational output; it is a gate of head fields. All other outputs are flop-driven.
- Reset values: w_valid=0, w_we=0, all w_* fields=0, m_ready=1 from the first cycle after reset.
- Reset/flush mid-stall discards both entries; the next cycle accepts new input.

Optional Feature:
- Macro WBPIPE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0], incremented each cycle with hv & !w_ready, saturating at 0xFFFFFFFF.
  - Adds output skid_hits [15:0], incremented on each skid load, wrapping.
  - Both are cleared by reset only, not by flush.
- Undefined: neither port nor their counters exist. Behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: default width constants (XLEN=32, RADDR_W=5), a payload struct typedef {instr, pc, we, waddr, wdata}, and a zero-payload constant.
- One natural sub-module: skid_buf_2, a generic 2-entry valid/ready buffer over an opaque payload vector. wb_pipe_skid instantiates it and adds flush, w_we gating and the optional counters.

Test Plan:
- Reset: after reset, m_ready=1, w_valid=0, w_we=0; w_pc=0 and w_wdata=0.
- Streaming: w_ready=1, feed pc 0x3000,0x3004,0x3008 back-to-back -> each appears on w_pc exactly 1 cycle later; w_valid continuous; m_ready stays 1.
- Back-pressure: hold w_ready=0 while sending A (pc 0x3000) then B (pc 0x3004) -> m_ready=0 after B; on w_ready=1, A then B drain in order; m_ready returns to 1 the cycle after A leaves.
- Flush: with both entries held, assert flush alongside m_valid=1 (pc 0x3010) -> next cycle w_valid=0, m_ready=1, all fields 0; entry 0x3010 never appears.
- r0 mask: send m_we=1, m_waddr=0, m_wdata=0xDEADBEEF with MASK_R0=1 -> w_valid=1, w_we=0. Repeat with MASK_R0=0 -> w_we=1.
- Counters (WBPIPE_STALL_CNT_EN): hold w_ready=0 for 5 cycles with one entry held -> stall_cnt=5; second entry arriving during the stall -> skid_hits=1.
